// File: rtl/relu_backward_array.sv
// ReLU backward pass over a packed vector: forward Z vectors leave a per-slot
// sign mask, and gradients are gated lane-by-lane by that mask through a two-stage pipeline.
module relu_backward_array #(
  parameter int dataWidth   = 32,
  parameter int pactivation = 128,
  parameter int maskDepth   = 64,
  localparam int addrWidth  = $clog2(maskDepth),
  localparam int vecWidth   = dataWidth * pactivation
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fwd_valid,
  input  logic [addrWidth-1:0] fwd_addr,
  input  logic [vecWidth-1:0]  fwd_z,
  input  logic                 grad_valid,
  output logic                 grad_ready,
  input  logic [addrWidth-1:0] grad_addr,
  input  logic [vecWidth-1:0]  grad_in,
  output logic                 dz_valid,
  input  logic                 dz_ready,
  output logic [vecWidth-1:0]  dz_out,
  output logic                 mask_err
);

  logic [pactivation-1:0] mask_mem [maskDepth];
  logic [maskDepth-1:0]   written_q, written_d;

  logic                   s1_valid_q, s1_valid_d;
  logic [vecWidth-1:0]    s1_grad_q, s1_grad_d;
  logic [pactivation-1:0] s1_mask_q, s1_mask_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [vecWidth-1:0]    s2_data_q, s2_data_d;
  logic                   mask_err_q, mask_err_d;

  logic [pactivation-1:0] fwd_mask;
  logic [pactivation-1:0] rd_mask;
  logic                   rd_bypass;
  logic                   rd_written;
  logic [vecWidth-1:0]    s1_masked;
  logic                   s2_open;
  logic                   s1_open;
  logic                   grad_accept;

  // A lane is positive when its sign bit is clear and it is not zero.
  always_comb begin
    fwd_mask = '0;
    for (int i = 0; i < pactivation; i++) begin
      fwd_mask[i] = ~fwd_z[i*dataWidth + dataWidth - 1] & (|fwd_z[i*dataWidth +: dataWidth]);
    end
  end

  // A same-cycle write to the slot being read wins over the stored mask.
  always_comb begin
    rd_bypass  = fwd_valid && (fwd_addr == grad_addr);
    rd_written = rd_bypass || written_q[grad_addr];
    rd_mask    = '0;
    if (rd_bypass) begin
      rd_mask = fwd_mask;
    end else if (written_q[grad_addr]) begin
      rd_mask = mask_mem[grad_addr];
    end
  end

  assign s2_open     = !s2_valid_q || dz_ready;
  assign s1_open     = !s1_valid_q || s2_open;
  assign grad_ready  = !rst && s1_open;
  assign grad_accept = grad_valid && grad_ready;

  always_comb begin
    s1_masked = '0;
    for (int i = 0; i < pactivation; i++) begin
      if (s1_mask_q[i]) begin
        s1_masked[i*dataWidth +: dataWidth] = s1_grad_q[i*dataWidth +: dataWidth];
      end
    end
  end

  // NOTE: every next-state signal gets its hold value first, so no path
  // through this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    written_d  = written_q;
    s1_valid_d = s1_valid_q;
    s1_grad_d  = s1_grad_q;
    s1_mask_d  = s1_mask_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    mask_err_d = mask_err_q;

    if (fwd_valid) begin
      written_d[fwd_addr] = 1'b1;
    end

    if (s1_open) begin
      s1_valid_d = grad_valid;
    end
    if (grad_accept) begin
      s1_grad_d = grad_in;
      s1_mask_d = rd_mask;
      if (!rd_written) begin
        mask_err_d = 1'b1;
      end
    end

    if (s2_open) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = s1_masked;
      end
    end
  end

  // NOTE: the mask store holds data only; validity lives in written_q, so the
  // array carries no reset and maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (fwd_valid) begin
      mask_mem[fwd_addr] <= fwd_mask;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      written_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_grad_q  <= '0;
      s1_mask_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      mask_err_q <= 1'b0;
    end else begin
      written_q  <= written_d;
      s1_valid_q <= s1_valid_d;
      s1_grad_q  <= s1_grad_d;
      s1_mask_q  <= s1_mask_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      mask_err_q <= mask_err_d;
    end
  end

  assign dz_valid = s2_valid_q;
  assign dz_out   = s2_data_q;
  assign mask_err = mask_err_q;

endmodule

// File: tb/tb_relu_backward_array.sv
// Directed bench for relu_backward_array: 8 lanes of 32 bits, 16 mask slots.
module tb_relu_backward_array;

  localparam int DW = 32;
  localparam int NL = 8;
  localparam int MD = 16;
  localparam int AW = 4;
  localparam int VW = DW * NL;

  logic          clk = 1'b0;
  logic          rst;
  logic          fwd_valid;
  logic [AW-1:0] fwd_addr;
  logic [VW-1:0] fwd_z;
  logic          grad_valid;
  logic          grad_ready;
  logic [AW-1:0] grad_addr;
  logic [VW-1:0] grad_in;
  logic          dz_valid;
  logic          dz_ready;
  logic [VW-1:0] dz_out;
  logic          mask_err;

  int total = 0;
  int bad   = 0;

  relu_backward_array #(
    .dataWidth  (DW),
    .pactivation(NL),
    .maskDepth  (MD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fwd_valid (fwd_valid),
    .fwd_addr  (fwd_addr),
    .fwd_z     (fwd_z),
    .grad_valid(grad_valid),
    .grad_ready(grad_ready),
    .grad_addr (grad_addr),
    .grad_in   (grad_in),
    .dz_valid  (dz_valid),
    .dz_ready  (dz_ready),
    .dz_out    (dz_out),
    .mask_err  (mask_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] pk(input logic [31:0] l0, l1, l2, l3, l4, l5, l6, l7);
    return {l7, l6, l5, l4, l3, l2, l1, l0};
  endfunction

  function automatic logic [VW-1:0] splat(input logic [31:0] v);
    return {NL{v}};
  endfunction

  function automatic logic [VW-1:0] apply(input logic [NL-1:0] m, input logic [VW-1:0] g);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < NL; i++) if (m[i]) r[i*DW +: DW] = g[i*DW +: DW];
    return r;
  endfunction

  function automatic logic [VW-1:0] ramp(input int k);
    logic [VW-1:0] r;
    for (int i = 0; i < NL; i++) r[i*DW +: DW] = 32'(32'h100 * k + i + 1);
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_slot(input logic [AW-1:0] a, input logic [VW-1:0] z);
    fwd_valid = 1'b1;
    fwd_addr  = a;
    fwd_z     = z;
    tick;
    fwd_valid = 1'b0;
  endtask

  task automatic send_one(input string tag, input logic [AW-1:0] a,
                          input logic [VW-1:0] g, input logic [VW-1:0] exp);
    grad_valid = 1'b1;
    grad_addr  = a;
    grad_in    = g;
    tick;
    grad_valid = 1'b0;
    fwd_valid  = 1'b0;
    check({tag, "_lat1"}, VW'(dz_valid), VW'(1'b0));
    tick;
    check({tag, "_valid"}, VW'(dz_valid), VW'(1'b1));
    check({tag, "_data"}, dz_out, exp);
    tick;
    check({tag, "_onecycle"}, VW'(dz_valid), VW'(1'b0));
  endtask

  logic [VW-1:0] z3;
  logic [VW-1:0] g_st [3];
  logic [VW-1:0] ga, gb;
  int idx, oidx, cnt;

  initial begin
    rst = 1'b1; fwd_valid = 1'b0; fwd_addr = '0; fwd_z = '0;
    grad_valid = 1'b0; grad_addr = '0; grad_in = '0; dz_ready = 1'b1;
    tick; tick;
    check("rst_dz_valid", VW'(dz_valid), VW'(1'b0));
    check("rst_dz_out", dz_out, '0);
    check("rst_mask_err", VW'(mask_err), VW'(1'b0));
    check("rst_grad_ready", VW'(grad_ready), VW'(1'b0));
    rst = 1'b0;
    #1;
    check("ready_after_rst", VW'(grad_ready), VW'(1'b1));
    tick;

    // Slot 3 mask: lanes 0,3,4,7 positive -> 8'h99.
    z3 = pk(32'd5, 32'hFFFF_FFFE, 32'd0, 32'h7FFF_FFFF,
            32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0100);
    write_slot(4'd3, z3);
    send_one("basic", 4'd3, splat(32'h10),
             pk(32'h10, 32'h0, 32'h0, 32'h10, 32'h10, 32'h0, 32'h0, 32'h10));

    write_slot(4'd5, splat(32'd1));

    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        grad_valid = 1'b1;
        grad_addr  = (c % 2 == 0) ? 4'd5 : 4'd3;
        grad_in    = ramp(c);
      end else begin
        grad_valid = 1'b0;
      end
      #1;
      if (c < 8) check($sformatf("stream_ready%0d", c), VW'(grad_ready), VW'(1'b1));
      if (c >= 2) check($sformatf("stream_valid%0d", c), VW'(dz_valid), VW'(c < 10));
      if (c >= 2 && c < 10)
        check($sformatf("stream_data%0d", c - 2), dz_out,
              ((c - 2) % 2 == 0) ? ramp(c - 2) : apply(8'h99, ramp(c - 2)));
      tick;
    end

    g_st[0] = ramp(20); g_st[1] = ramp(21); g_st[2] = ramp(22);
    idx = 0; oidx = 0;
    grad_addr = 4'd5;
    for (int c = 0; c < 12; c++) begin
      dz_ready   = (c >= 5);
      grad_valid = (idx < 3);
      if (idx < 3) grad_in = g_st[idx];
      #1;
      if (c >= 2 && c <= 4) begin
        check($sformatf("stall_ready%0d", c), VW'(grad_ready), VW'(1'b0));
        check($sformatf("stall_accepts%0d", c), VW'(idx), VW'(2));
        check($sformatf("stall_valid%0d", c), VW'(dz_valid), VW'(1'b1));
        check($sformatf("stall_hold%0d", c), dz_out, g_st[0]);
      end
      if (dz_valid && dz_ready) begin
        if (oidx < 3) check($sformatf("stall_out%0d", oidx), dz_out, g_st[oidx]);
        oidx++;
      end
      if (grad_valid && grad_ready) idx++;
      tick;
    end
    grad_valid = 1'b0;
    check("stall_in_count", VW'(idx), VW'(3));
    check("stall_out_count", VW'(oidx), VW'(3));

    ga = pk(32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7);
    fwd_valid = 1'b1; fwd_addr = 4'd7;
    fwd_z = pk(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'h7FFF_FFFF);
    grad_valid = 1'b1; grad_addr = 4'd7; grad_in = ga;
    tick;
    grad_valid = 1'b0;
    fwd_z = pk(32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'hFFFF_FFF0,
               32'hFFFF_FFFF, 32'h8000_0001, 32'd0, 32'hFFFF_FFFF);
    tick;
    fwd_valid = 1'b0;
    check("bypass_valid", VW'(dz_valid), VW'(1'b1));
    check("bypass_data", dz_out, ga);
    check("bypass_no_err", VW'(mask_err), VW'(1'b0));
    tick;
    send_one("rewrite7", 4'd7, ga, '0);
    gb = pk(32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5, 32'hB6, 32'hB7);
    send_one("other_slot5", 4'd5, gb, gb);
    check("err_still_clear", VW'(mask_err), VW'(1'b0));

    send_one("unwritten12", 4'd12, ga, '0);
    check("err_set", VW'(mask_err), VW'(1'b1));
    tick; tick; tick;
    check("err_sticky", VW'(mask_err), VW'(1'b1));
    rst = 1'b1;
    #1;
    check("err_rst_clear", VW'(mask_err), VW'(1'b0));
    tick;
    rst = 1'b0;
    #1;
    check("ready_after_rst2", VW'(grad_ready), VW'(1'b1));
    tick;

    write_slot(4'd5, splat(32'd1));
    dz_ready = 1'b0;
    grad_valid = 1'b1; grad_addr = 4'd5; grad_in = ga;
    tick;
    grad_in = gb;
    tick;
    grad_valid = 1'b0;
    check("full_valid", VW'(dz_valid), VW'(1'b1));
    check("full_ready", VW'(grad_ready), VW'(1'b0));
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", VW'(dz_valid), VW'(1'b0));
    check("midrst_data", dz_out, '0);
    check("midrst_ready", VW'(grad_ready), VW'(1'b0));
    tick;
    rst = 1'b0;
    dz_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (dz_valid) cnt++;
    end
    check("midrst_no_output", VW'(cnt), VW'(0));
    send_one("post_rst_unwritten", 4'd5, gb, '0);
    check("post_rst_err", VW'(mask_err), VW'(1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/relu_backward_array.md
RELU_BACKWARD_ARRAY -- requirements
Module: relu_backward_array

Interface
REQ-001 SHALL have parameter dataWidth, default 32, meaning width of one signed two's-complement lane.
REQ-002 SHALL have parameter pactivation, default 128, meaning lanes per vector.
REQ-003 SHALL have parameter maskDepth, default 64, meaning number of stored mask vectors; addrWidth = clog2(maskDepth).
REQ-004 SHALL have port clk  input  1  system clock; all logic is rising-edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port fwd_valid  input  1  forward pre-activation vector present this cycle.
REQ-007 SHALL have port fwd_addr  input  addrWidth  mask slot to write.
REQ-008 SHALL have port fwd_z  input  dataWidth*pactivation  forward Z vector; lane i at bits [dataWidth*(i+1)-1 : dataWidth*i].
REQ-009 SHALL have port grad_valid  input  1  incoming gradient dA valid.
REQ-010 SHALL have port grad_ready  output  1  block accepts gradient this cycle.
REQ-011 SHALL have port grad_addr  input  addrWidth  mask slot to apply.
REQ-012 SHALL have port grad_in  input  dataWidth*pactivation  dA vector, same lane packing.
REQ-013 SHALL have port dz_valid  output  1  output gradient valid.
REQ-014 SHALL have port dz_ready  input  1  downstream accepts output.
REQ-015 SHALL have port dz_out  output  dataWidth*pactivation  dZ vector.
REQ-016 SHALL have port mask_err  output  1  sticky flag: gradient applied to unwritten slot.

Function
REQ-017 Mask capture: on fwd_valid, slot fwd_addr SHALL store pactivation bits, bit i = 1 iff lane i of fwd_z is strictly positive (sign 0 and nonzero); slot marked written. fwd is never back-pressured.
REQ-018 Gradient handshake: transfer occurs when grad_valid && grad_ready; output transfer when dz_valid && dz_ready.
REQ-019 Pipeline SHALL be two registered stages: S1 (mask read, grad/addr registered), S2 (masked output register driving dz_*).
REQ-020 Latency SHALL be exactly 2 cycles from accepted gradient to dz_valid with dz_ready held high; throughput one vector per cycle, no bubbles.
REQ-021 dz_out lane i SHALL equal grad_in lane i if mask bit i = 1, else all-zero; no arithmetic, no width change.
REQ-022 grad_ready SHALL be 1 when S1 empty or S1 can advance (S2 empty or dz_ready); grad_ready SHALL not depend combinationally on grad_valid.
REQ-023 Stall: with dz_ready low and both stages full, grad_ready SHALL be 0 and dz_out/dz_valid SHALL hold stable until accepted.
REQ-024 Same-cycle fwd write and gradient accept to the same slot SHALL use the newly written mask (write-first bypass).
REQ-025 A fwd write to a slot already captured in S1 SHALL not alter that in-flight vector.
REQ-026 Gradient to an unwritten slot SHALL produce an all-zero dz_out and set mask_err; mask_err stays 1 until reset.
REQ-027 Rewriting a slot SHALL overwrite its mask; no other slot changes.

Reset
REQ-028 rst SHALL immediately clear: S1/S2 valid, dz_valid=0, dz_out=0, mask_err=0, all slot written flags=0.
REQ-029 grad_ready SHALL be 0 while rst is high and 1 in the first cycle after deassertion.
REQ-030 Reset mid-operation SHALL discard in-flight vectors with no dz_valid pulse emitted for them; mask contents need not clear but are treated as unwritten.

Verification
REQ-031 Write slot 3 with lanes {5, -2, 0, 0x7FFFFFFF, ...}; gradient slot 3 with all lanes 0x00000010, dz_ready=1 -> 2 cycles later dz_out lanes {0x10, 0, 0, 0x10, ...}, dz_valid=1 for one cycle.
REQ-032 Stream 8 gradients back-to-back, dz_ready=1 -> 8 consecutive dz_valid cycles, in order, starting cycle 2.
REQ-033 dz_ready=0 for 5 cycles with 3 gradients offered -> grad_ready drops after 2 accepts, dz_out stable, no loss/duplication after release.
REQ-034 Same-cycle fwd write slot 7 (all positive) and gradient slot 7 -> dz_out equals grad_in in full.
REQ-035 Gradient to never-written slot 12 -> dz_out all zero, mask_err=1 and held; assert rst -> mask_err=0.
REQ-036 Assert rst with both stages full -> dz_valid=0 immediately, no output for discarded vectors after release.
